// File: rtl/hls_ctrl_pkg.sv
// Shared types and GPIO bit-map constants for the AXI-GPIO <-> HLS ap_ctrl bridge.
package hls_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } ch_state_e;

  localparam int CH_STRIDE = 4;

  // Write-side (GPIO_O) offsets within a channel nibble
  localparam int TRIG_OFS = 0;
  localparam int CLR_OFS  = 1;

  // Read-side (GPIO_I) offsets within a channel nibble
  localparam int DONE_OFS = 0;
  localparam int BUSY_OFS = 1;
  localparam int IDLE_OFS = 2;
  localparam int ERR_OFS  = 3;

endpackage

// File: rtl/hls_ctrl_channel.sv
// One HLS kernel channel: ap_start handshake FSM with sticky done/error flags.
// Optional RUN watchdog when HLS_CTRL_TIMEOUT_EN is defined.
module hls_ctrl_channel
  import hls_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 1048576
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic trig_i,
  input  logic clr_i,
  input  logic done_i,
  output logic start_o,
  output logic busy_o,
  output logic done_stk_o,
  output logic err_stk_o
);

  ch_state_e state_q, state_d;
  logic      done_q, done_d;
  logic      err_q, err_d;
  logic      timeout_w;

`ifdef HLS_CTRL_TIMEOUT_EN
  logic [31:0] cnt_q, cnt_d;

  // Counter sits at zero outside RUN, so it is fresh on every entry to RUN.
  assign cnt_d     = (state_q == ST_RUN) ? cnt_q + 32'd1 : 32'd0;
  assign timeout_w = (state_q == ST_RUN) && (cnt_q == 32'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) cnt_q <= 32'd0;
    else          cnt_q <= cnt_d;
  end
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT_CYC);
  assign timeout_w      = 1'b0;
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d = state_q;
    done_d  = done_q;
    err_d   = err_q;
    if (clr_i) err_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (trig_i) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (trig_i) err_d = 1'b1;
        if (done_i) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else if (timeout_w) begin
          state_d = ST_IDLE;
          done_d  = 1'b0;
          err_d   = 1'b1;
        end
      end
      ST_DONE: begin
        if (trig_i) begin
          state_d = ST_RUN;
          done_d  = 1'b0;
        end else if (clr_i) begin
          state_d = ST_IDLE;
          done_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    // NOTE: state registers use <= so every flop samples pre-edge values, whatever the statement order.
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign start_o    = (state_q == ST_RUN);
  assign busy_o     = (state_q == ST_RUN);
  assign done_stk_o = done_q;
  assign err_stk_o  = err_q;

endmodule

// File: rtl/hls_ctrl_gpio_bridge.sv
// AXI-GPIO <-> HLS ap_ctrl bridge: start handshakes, sticky done, reset stretchers, levels.
// Define HLS_CTRL_TIMEOUT_EN to add a per-channel RUN watchdog of TIMEOUT_CYC cycles.
module hls_ctrl_gpio_bridge
  import hls_ctrl_pkg::*;
#(
  parameter int          GPIO_W      = 32,
  parameter int          N_CH        = 4,
  parameter int          N_RST       = 2,
  parameter int          N_LVL       = 2,
  parameter int          RST_PULSE   = 4,
  parameter int unsigned TIMEOUT_CYC = 1048576
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic [GPIO_W-1:0] GPIO_O,
  input  logic [GPIO_W-1:0] GPIO_T,
  output logic [GPIO_W-1:0] GPIO_I,
  output logic [N_CH-1:0]   ch_start,
  input  logic [N_CH-1:0]   ch_done,
  input  logic [N_CH-1:0]   ch_idle,
  output logic [N_RST-1:0]  rst_out,
  input  logic [N_RST-1:0]  rst_busy,
  output logic [N_LVL-1:0]  lvl_out
);

  localparam int RST_BASE = CH_STRIDE * N_CH;
  localparam int LVL_BASE = CH_STRIDE * (N_CH + N_RST);
  localparam int PW       = $clog2(RST_PULSE + 1);

  if (LVL_BASE + N_LVL > GPIO_W) begin : g_bad_map
    $error("hls_ctrl_gpio_bridge: GPIO bit map does not fit in GPIO_W");
  end

  function automatic logic [GPIO_W-1:0] status_mask();
    logic [GPIO_W-1:0] m;
    m = '0;
    for (int i = 0; i < N_CH; i++) m[CH_STRIDE*i +: CH_STRIDE] = '1;
    for (int j = 0; j < N_RST; j++) m[RST_BASE + CH_STRIDE*j] = 1'b1;
    return m;
  endfunction

  localparam logic [GPIO_W-1:0] STATUS_MASK = status_mask();

  logic [GPIO_W-1:0] o_q, edge_w, gpio_i_d, gpio_i_q;
  logic [N_CH-1:0]   ch_busy, done_stk, err_stk;
  logic [N_RST-1:0]  rst_q, rst_d;
  logic [PW-1:0]     pcnt_q [N_RST];
  logic [PW-1:0]     pcnt_d [N_RST];
  logic              unused_bits;

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) o_q <= '0;
    else           o_q <= GPIO_O;
  end

  assign edge_w      = GPIO_O & ~o_q;
  assign unused_bits = ^{GPIO_T, edge_w};

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    hls_ctrl_channel #(
      .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_ch (
      .clk_i     (ap_clk),
      .rst_n_i   (ap_rst_n),
      .trig_i    (edge_w[CH_STRIDE*i + TRIG_OFS]),
      .clr_i     (edge_w[CH_STRIDE*i + CLR_OFS]),
      .done_i    (ch_done[i]),
      .start_o   (ch_start[i]),
      .busy_o    (ch_busy[i]),
      .done_stk_o(done_stk[i]),
      .err_stk_o (err_stk[i])
    );
  end

  // Resetter: minimum pulse counted down first, then held while the resetter reports busy.
  always_comb begin
    for (int j = 0; j < N_RST; j++) begin
      rst_d[j]  = rst_q[j];
      pcnt_d[j] = pcnt_q[j];
      if (!rst_q[j]) begin
        if (edge_w[RST_BASE + CH_STRIDE*j]) begin
          rst_d[j]  = 1'b1;
          pcnt_d[j] = PW'(RST_PULSE - 1);
        end
      end else if (pcnt_q[j] != '0) begin
        pcnt_d[j] = pcnt_q[j] - PW'(1);
      end else if (!rst_busy[j]) begin
        rst_d[j] = 1'b0;
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    // NOTE: these tiny counter arrays are control state and are reset; bulk data RAMs would not be.
    if (!ap_rst_n) begin
      rst_q <= '0;
      for (int j = 0; j < N_RST; j++) pcnt_q[j] <= '0;
    end else begin
      rst_q <= rst_d;
      for (int j = 0; j < N_RST; j++) pcnt_q[j] <= pcnt_d[j];
    end
  end

  always_comb begin
    gpio_i_d = '1;
    for (int i = 0; i < N_CH; i++) begin
      gpio_i_d[CH_STRIDE*i + DONE_OFS] = done_stk[i];
      gpio_i_d[CH_STRIDE*i + BUSY_OFS] = ch_busy[i];
      gpio_i_d[CH_STRIDE*i + IDLE_OFS] = ch_idle[i];
      gpio_i_d[CH_STRIDE*i + ERR_OFS]  = err_stk[i];
    end
    for (int j = 0; j < N_RST; j++) gpio_i_d[RST_BASE + CH_STRIDE*j] = rst_q[j] | rst_busy[j];
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) gpio_i_q <= ~STATUS_MASK;
    else           gpio_i_q <= gpio_i_d;
  end

  assign GPIO_I  = gpio_i_q;
  assign rst_out = rst_q;
  assign lvl_out = o_q[LVL_BASE +: N_LVL];

endmodule
